// File: rtl/rr_arb_mux_4_1_if.sv
// Stream bundle for rr_arb_mux_4_1: four request channels in, one registered beat out.
// master = producers/consumer side, slave = arbiter side.
interface rr_arb_mux_4_1_if #(
  parameter int WIDTH = 4
);
  logic [3:0]         in_valid;
  logic [4*WIDTH-1:0] in_data;
  logic [3:0]         in_ready;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic [1:0]         out_src;
  logic               out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_src
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_src
  );
endinterface

// File: rtl/rr_arb_mux_4_1.sv
// 4-channel round-robin arbiter + AND/OR 4:1 mux into a registered output; 1-cycle latency,
// accepts only while the output register is empty or draining. Optional RR_ARB_GRANT_CNT_EN adds per-channel grant counters.
module rr_arb_mux_4_1 #(
  parameter int WIDTH   = 4,
  parameter int PTR_RST = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  rr_arb_mux_4_1_if.slave     io
`ifdef RR_ARB_GRANT_CNT_EN
  ,
  output logic [4*16-1:0]     grant_cnt
`endif
);

  localparam logic [1:0] PTR_INIT = 2'(PTR_RST);

  logic [1:0]       ptr_q, ptr_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [1:0]       out_src_q, out_src_d;

  logic             space;
  logic             any;
  logic [1:0]       win;
  logic [1:0]       cand;
  logic             found;
  logic [3:0]       sel_oh;
  logic [3:0]       rdy;
  logic             xfer;
  logic [WIDTH-1:0] d0, d1, d2, d3;
  logic [WIDTH-1:0] mux_dat;

  assign space = ~out_valid_q | io.out_ready;
  assign any   = |io.in_valid;

  // First requesting channel scanning upward from ptr, wrapping mod 4.
  always_comb begin
    win   = ptr_q;
    cand  = '0;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cand = ptr_q + 2'(k);
      if (!found && io.in_valid[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end
  end

  assign sel_oh = { win[1] &  win[0],
                    win[1] & ~win[0],
                   ~win[1] &  win[0],
                   ~win[1] & ~win[0]};

  assign d0 = io.in_data[0*WIDTH +: WIDTH];
  assign d1 = io.in_data[1*WIDTH +: WIDTH];
  assign d2 = io.in_data[2*WIDTH +: WIDTH];
  assign d3 = io.in_data[3*WIDTH +: WIDTH];

  assign mux_dat = ({WIDTH{sel_oh[0]}} & d0) |
                   ({WIDTH{sel_oh[1]}} & d1) |
                   ({WIDTH{sel_oh[2]}} & d2) |
                   ({WIDTH{sel_oh[3]}} & d3);

  assign rdy         = {4{space & any & rst_n}} & sel_oh;
  assign io.in_ready = rdy;
  assign xfer        = |(io.in_valid & rdy);

  always_comb begin
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    if (xfer) begin
      // Reload covers the simultaneous drain case, sustaining one beat per cycle.
      out_valid_d = 1'b1;
      out_data_d  = mux_dat;
      out_src_d   = win;
      ptr_d       = win + 2'd1;
    end else if (io.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= PTR_INIT;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
    end else begin
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
    end
  end

  assign io.out_valid = out_valid_q;
  assign io.out_data  = out_data_q;
  assign io.out_src   = out_src_q;

`ifdef RR_ARB_GRANT_CNT_EN
  logic [3:0][15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < 4; i++) begin
      if (io.in_valid[i] & rdy[i]) cnt_d[i] = cnt_q[i] + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign grant_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_rr_arb_mux_4_1.sv
// Directed bench for rr_arb_mux_4_1: reset, rotation, sparse requests, backpressure, mid-stream reset,
// and grant counters when RR_ARB_GRANT_CNT_EN is defined.
module tb_rr_arb_mux_4_1;
  logic clk = 1'b0;
  logic rst_n;
  int   n_chk = 0;
  int   n_err = 0;

  rr_arb_mux_4_1_if #(.WIDTH(4)) bus ();

`ifdef RR_ARB_GRANT_CNT_EN
  logic [63:0] grant_cnt;
  rr_arb_mux_4_1 #(.WIDTH(4), .PTR_RST(0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .io        (bus.slave),
    .grant_cnt (grant_cnt)
  );
`else
  rr_arb_mux_4_1 #(.WIDTH(4), .PTR_RST(0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus.slave)
  );
`endif

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 4'hF;
    bus.in_data   = {4'hD, 4'hC, 4'hB, 4'hA};
    bus.out_ready = 1'b1;

    #12;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_in_ready",  bus.in_ready,  0);
    check("rst_out_src",   bus.out_src,   0);
    check("rst_out_data",  bus.out_data,  0);

    rst_n = 1'b1;
    #1;
    check("first_in_ready", bus.in_ready, 4'b0001);

    // All four valid, out_ready held: grants rotate 0,1,2,3,0.
    for (int k = 0; k < 5; k++) begin
      tick();
      check("rot_valid", bus.out_valid, 1);
      check("rot_src",   bus.out_src,   k % 4);
      check("rot_data",  bus.out_data,  4'hA + 4'(k % 4));
    end

    // ptr=1, only ch2 valid with data 5 -> ch2 granted, ptr becomes 3.
    bus.in_valid = 4'b0100;
    bus.in_data  = {4'hD, 4'h5, 4'hB, 4'hA};
    #1;
    check("sparse_rdy_a", bus.in_ready, 4'b0100);
    tick();
    check("sparse_src_a",  bus.out_src,  2);
    check("sparse_data_a", bus.out_data, 5);
    // ptr=3 now: scan 3,0,1,2 still lands on ch2 and ptr stays 3.
    check("sparse_rdy_b", bus.in_ready, 4'b0100);
    tick();
    check("sparse_src_b",  bus.out_src,  2);
    check("sparse_data_b", bus.out_data, 5);

    bus.in_valid = 4'b1010;
    bus.in_data  = {4'hD, 4'hC, 4'hB, 4'hA};
    #1;
    check("ch13_rdy", bus.in_ready, 4'b1000);
    tick();
    check("ch13_src",  bus.out_src,  3);
    check("ch13_data", bus.out_data, 4'hD);

    // Backpressure on the held ch3 beat.
    bus.in_valid  = 4'hF;
    bus.out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("bp_in_ready", bus.in_ready,  0);
      check("bp_valid",    bus.out_valid, 1);
      check("bp_src",      bus.out_src,   3);
      check("bp_data",     bus.out_data,  4'hD);
      tick();
    end
    bus.out_ready = 1'b1;
    #1;
    check("bp_release_rdy", bus.in_ready, 4'b0001);
    tick();
    check("bp_reload_valid", bus.out_valid, 1);
    check("bp_reload_src",   bus.out_src,   0);
    check("bp_reload_data",  bus.out_data,  4'hA);

    // Drain with no requests: valid drops, payload holds.
    bus.in_valid = 4'h0;
    #1;
    check("idle_rdy", bus.in_ready, 0);
    tick();
    check("drain_valid", bus.out_valid, 0);
    check("drain_src",   bus.out_src,   0);
    check("drain_data",  bus.out_data,  4'hA);

    // Mid-stream reset: ptr=1, so ch1 loads, then reset drops it asynchronously.
    bus.in_valid = 4'hF;
    tick();
    check("pre_rst_valid", bus.out_valid, 1);
    check("pre_rst_src",   bus.out_src,   1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", bus.out_valid, 0);
    check("mid_rst_rdy",   bus.in_ready,  0);
    #2;
    rst_n = 1'b1;
    #1;
    check("post_rst_rdy", bus.in_ready, 4'b0001);
    tick();
    check("post_rst_src",  bus.out_src,  0);
    check("post_rst_data", bus.out_data, 4'hA);

`ifdef RR_ARB_GRANT_CNT_EN
    rst_n = 1'b0;
    #2;
    check("cnt_rst", grant_cnt, 0);
    rst_n = 1'b1;
    bus.in_valid = 4'b0010;
    for (int k = 0; k < 10; k++) tick();
    check("cnt_ch1_10", grant_cnt[31:16], 10);
    check("cnt_ch0_0",  grant_cnt[15:0],  0);
    check("cnt_ch23_0", grant_cnt[63:32], 0);
    bus.in_valid = 4'b0001;
    for (int k = 0; k < 65535; k++) tick();
    check("cnt_ch0_max", grant_cnt[15:0], 16'hFFFF);
    tick();
    check("cnt_ch0_wrap", grant_cnt[15:0], 0);
    check("cnt_ch1_keep", grant_cnt[31:16], 10);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
